// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out controller:
// FSM state encoding and default word/gap sizes.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } piso_state_e;

   localparam int PISO_WIDTH_DEFAULT = 4;
   localparam int PISO_GAP_DEFAULT   = 1;
   localparam int PISO_GAP_CNT_W     = 4;

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register with full flag; ready is the registered
// inverse of full so the upstream handshake has no combinational path.
module piso_hold_reg
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   input  logic             i_pop,
   output logic             o_ready,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;

   // Pop and accept never coincide: pop needs full, accept needs empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end else if (i_valid && !r_full) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end
   end

   assign o_ready = !r_full;
   assign o_full  = r_full;
   assign o_data  = r_data;

endmodule

// File: rtl/parallel_in_serial_out_ctrl.sv
// Serializes parallel words MSB first with a programmable idle gap between
// frames; a one-entry holding register lets the next word queue up early.
module parallel_in_serial_out_ctrl
   import piso_pkg::*;
#(
   parameter int WIDTH      = PISO_WIDTH_DEFAULT,
   parameter int GAP_CYCLES = PISO_GAP_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] LoadData,
   input  logic             LoadValid,
   output logic             LoadReady,
   output logic             ShiftEn,
   output logic             ShiftOut,
   output logic             FrameDone,
   output logic             Busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [PISO_GAP_CNT_W-1:0] LAST_GAP =
      (GAP_CYCLES > 0) ? PISO_GAP_CNT_W'(GAP_CYCLES - 1) : '0;

   piso_state_e               r_state;
   piso_state_e               w_nextState;
   logic [WIDTH-1:0]          r_shift;
   logic [CNT_W-1:0]          r_bitCnt;
   logic [PISO_GAP_CNT_W-1:0] r_gapCnt;
   logic                      r_shiftEn;
   logic                      r_frameDone;
   logic                      w_holdFull;
   logic [WIDTH-1:0]          w_holdData;
   logic                      w_pop;
   logic                      w_lastBit;

   piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (LoadData),
      .i_valid (LoadValid),
      .i_pop   (w_pop),
      .o_ready (LoadReady),
      .o_full  (w_holdFull),
      .o_data  (w_holdData)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Every entry into SHIFT pops the holding register into the shifter.
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      w_lastBit   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_holdFull) begin
               w_nextState = SHIFT;
               w_pop       = 1'b1;
            end
         end
         SHIFT: begin
            if (r_bitCnt == LAST_BIT) begin
               w_lastBit = 1'b1;
               if (GAP_CYCLES > 0) begin
                  w_nextState = GAP;
               end else if (w_holdFull) begin
                  w_nextState = SHIFT;
                  w_pop       = 1'b1;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         GAP: begin
            if (r_gapCnt == LAST_GAP) begin
               if (w_holdFull) begin
                  w_nextState = SHIFT;
                  w_pop       = 1'b1;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Zero fill on shift leaves the register clear after the last bit,
   // so ShiftOut reads 0 in GAP and IDLE without extra gating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_bitCnt    <= '0;
         r_gapCnt    <= '0;
         r_shiftEn   <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_shiftEn   <= (w_nextState == SHIFT);
         r_frameDone <= w_lastBit;
         if (w_pop) begin
            r_shift  <= w_holdData;
            r_bitCnt <= '0;
         end else if (r_state == SHIFT) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            if (!w_lastBit) begin
               r_bitCnt <= r_bitCnt + 1'b1;
            end
         end
         if (r_state == GAP) begin
            r_gapCnt <= r_gapCnt + 1'b1;
         end else begin
            r_gapCnt <= '0;
         end
      end
   end

   assign ShiftEn   = r_shiftEn;
   assign ShiftOut  = r_shift[WIDTH-1];
   assign FrameDone = r_frameDone;
   assign Busy      = (r_state != IDLE) || w_holdFull;

endmodule

// File: tb/tb_parallel_in_serial_out_ctrl.sv
// Bench for parallel_in_serial_out_ctrl: two instances (gap 1 and gap 0)
// checked every cycle against a frame-schedule model, plus directed cases.
module tb_parallel_in_serial_out_ctrl;

   localparam int W  = 4;
   localparam int NU = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] loadData  [NU];
   logic         loadValid [NU];
   wire          loadReady [NU];
   wire          shiftEn   [NU];
   wire          shiftOut  [NU];
   wire          frameDone [NU];
   wire          busy      [NU];

   parallel_in_serial_out_ctrl #(.WIDTH(W), .GAP_CYCLES(1)) dutGap1 (
      .clk(clk), .rst_n(rst_n), .LoadData(loadData[0]), .LoadValid(loadValid[0]),
      .LoadReady(loadReady[0]), .ShiftEn(shiftEn[0]), .ShiftOut(shiftOut[0]),
      .FrameDone(frameDone[0]), .Busy(busy[0])
   );

   parallel_in_serial_out_ctrl #(.WIDTH(W), .GAP_CYCLES(0)) dutGap0 (
      .clk(clk), .rst_n(rst_n), .LoadData(loadData[1]), .LoadValid(loadValid[1]),
      .LoadReady(loadReady[1]), .ShiftEn(shiftEn[1]), .ShiftOut(shiftOut[1]),
      .FrameDone(frameDone[1]), .Busy(busy[1])
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic int gapOf(int u);
      return (u == 0) ? 1 : 0;
   endfunction

   task automatic checkOutput(string name, int u, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, u, act, exp, $time);
      end
   endtask

   // Model: a started frame books its bits, FrameDone and busy window into
   // a per-cycle schedule; a waiting word starts at the first edge allowed.
   int           cycleCnt   = 0;
   bit           modelValid = 1'b0;
   bit           holdFull   [NU];
   logic [W-1:0] holdWord   [NU];
   int           nextStart  [NU];
   int           busyUntil  [NU];
   bit           expEn      [NU][64];
   bit           expBit     [NU][64];
   bit           expDone    [NU][64];
   bit           expReady   [NU];
   bit           expBusy    [NU];

   always @(posedge clk or negedge rst_n) begin
      int k;
      int prev;
      bit wasFull;
      if (!rst_n) begin
         for (int u = 0; u < NU; u++) begin
            holdFull[u]  = 1'b0;
            nextStart[u] = 0;
            busyUntil[u] = -1;
            expReady[u]  = 1'b1;
            expBusy[u]   = 1'b0;
            for (int s = 0; s < 64; s++) begin
               expEn[u][s]   = 1'b0;
               expBit[u][s]  = 1'b0;
               expDone[u][s] = 1'b0;
            end
         end
         modelValid = 1'b1;
      end else begin
         cycleCnt++;
         k    = cycleCnt;
         prev = (k + 63) % 64;
         for (int u = 0; u < NU; u++) begin
            expEn[u][prev]   = 1'b0;
            expBit[u][prev]  = 1'b0;
            expDone[u][prev] = 1'b0;
            wasFull = holdFull[u];
            if (holdFull[u] && k >= nextStart[u]) begin
               for (int i = 0; i < W; i++) begin
                  expEn[u][(k + i) % 64]  = 1'b1;
                  expBit[u][(k + i) % 64] = holdWord[u][W-1-i];
               end
               expDone[u][(k + W) % 64] = 1'b1;
               nextStart[u] = k + W + gapOf(u);
               busyUntil[u] = k + W + gapOf(u) - 1;
               holdFull[u]  = 1'b0;
            end
            if (loadValid[u] && !wasFull) begin
               holdFull[u] = 1'b1;
               holdWord[u] = loadData[u];
            end
            expReady[u] = !holdFull[u];
            expBusy[u]  = holdFull[u] || (k <= busyUntil[u]);
         end
      end
   end

   // Every falling edge: reset values while in reset, model values otherwise.
   always @(negedge clk) begin
      int s;
      s = cycleCnt % 64;
      for (int u = 0; u < NU; u++) begin
         if (!rst_n) begin
            checkOutput("rstLoadReady", u, 32'(loadReady[u]), 32'd1);
            checkOutput("rstShiftEn", u, 32'(shiftEn[u]), 32'd0);
            checkOutput("rstShiftOut", u, 32'(shiftOut[u]), 32'd0);
            checkOutput("rstFrameDone", u, 32'(frameDone[u]), 32'd0);
            checkOutput("rstBusy", u, 32'(busy[u]), 32'd0);
         end else if (modelValid) begin
            checkOutput("shiftEn", u, 32'(shiftEn[u]), 32'(expEn[u][s]));
            checkOutput("shiftOut", u, 32'(shiftOut[u]), 32'(expEn[u][s] & expBit[u][s]));
            checkOutput("frameDone", u, 32'(frameDone[u]), 32'(expDone[u][s]));
            checkOutput("busy", u, 32'(busy[u]), 32'(expBusy[u]));
            checkOutput("loadReady", u, 32'(loadReady[u]), 32'(expReady[u]));
         end
      end
   end

   // FrameDone pulse counter and a serial-in loopback register on dut0.
   int         doneCnt [NU] = '{0, 0};
   logic [3:0] sipo = 4'd0;

   always @(negedge clk) begin
      for (int u = 0; u < NU; u++) begin
         if (rst_n === 1'b1 && frameDone[u] === 1'b1) doneCnt[u]++;
      end
   end

   always @(posedge clk) begin
      if (shiftEn[0]) sipo <= {sipo[2:0], shiftOut[0]};
   end

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(int u, logic [W-1:0] word);
      bit r;
      bit taken;
      taken = 1'b0;
      loadData[u]  = word;
      loadValid[u] = 1'b1;
      for (int i = 0; i < 50 && !taken; i++) begin
         r = loadReady[u];
         waitCycle();
         if (r) taken = 1'b1;
      end
      loadValid[u] = 1'b0;
      if (!taken) checkOutput("acceptTimeout", u, 32'd0, 32'd1);
   endtask

   task automatic collectBits(int u, int n, output logic [31:0] bits, output bit enAll);
      int guard;
      guard = 0;
      while (shiftEn[u] !== 1'b1 && guard < 40) begin
         waitCycle();
         guard++;
      end
      if (shiftEn[u] !== 1'b1) checkOutput("shiftEnTimeout", u, 32'd0, 32'd1);
      bits  = '0;
      enAll = 1'b1;
      for (int i = 0; i < n; i++) begin
         bits  = {bits[30:0], shiftOut[u]};
         enAll = enAll & shiftEn[u];
         waitCycle();
      end
   endtask

   logic [31:0] bits;
   bit          enAll;
   int          doneBefore;

   initial begin
      rst_n = 1'b0;
      for (int u = 0; u < NU; u++) begin
         loadValid[u] = 1'b0;
         loadData[u]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstLoadReadyLit", 0, 32'(loadReady[0]), 32'd1);
      checkOutput("rstBusyLit", 0, 32'(busy[0]), 32'd0);
      rst_n = 1'b1;
      waitCycle();
      waitCycle();

      // Single word from idle: 1,0,1,1 then FrameDone, one gap, idle.
      fork
         applyStimulus(0, 4'b1011);
         collectBits(0, 4, bits, enAll);
      join
      checkOutput("w1011Bits", 0, bits, 32'hB);
      checkOutput("w1011EnAll", 0, 32'(enAll), 32'd1);
      checkOutput("w1011Done", 0, 32'(frameDone[0]), 32'd1);
      checkOutput("w1011GapEn", 0, 32'(shiftEn[0]), 32'd0);
      waitCycle();
      checkOutput("w1011IdleBusy", 0, 32'(busy[0]), 32'd0);
      checkOutput("w1011DoneOnce", 0, 32'(frameDone[0]), 32'd0);
      repeat (2) waitCycle();

      // Held LoadValid: A then 5 separated by the gap, two FrameDone pulses.
      doneBefore = doneCnt[0];
      fork
         begin
            applyStimulus(0, 4'hA);
            applyStimulus(0, 4'h5);
         end
         collectBits(0, 9, bits, enAll);
      join
      repeat (3) waitCycle();
      checkOutput("a5Stream", 0, bits, 32'(9'b1010_0_0101));
      checkOutput("a5DonePulses", 0, 32'(doneCnt[0] - doneBefore), 32'd2);

      // No gap: C and 3 stream for eight continuous cycles.
      fork
         begin
            applyStimulus(1, 4'hC);
            applyStimulus(1, 4'h3);
         end
         collectBits(1, 8, bits, enAll);
      join
      checkOutput("c3Stream", 1, bits, 32'hC3);
      checkOutput("c3EnContinuous", 1, 32'(enAll), 32'd1);
      repeat (3) waitCycle();

      // Third word offered while the holding register is full.
      fork
         begin
            applyStimulus(0, 4'h7);
            applyStimulus(0, 4'h2);
            checkOutput("fullReadyLow", 0, 32'(loadReady[0]), 32'd0);
            applyStimulus(0, 4'hE);
         end
         collectBits(0, 14, bits, enAll);
      join
      checkOutput("threeWordStream", 0, bits, 32'(14'b0111_0_0010_0_1110));
      repeat (3) waitCycle();

      // Reset two bits into a frame of F; no FrameDone, then a clean 6.
      applyStimulus(0, 4'hF);
      waitCycle();
      waitCycle();
      #5;
      doneBefore = doneCnt[0];
      rst_n = 1'b0;
      #1;
      checkOutput("midRstShiftEn", 0, 32'(shiftEn[0]), 32'd0);
      checkOutput("midRstShiftOut", 0, 32'(shiftOut[0]), 32'd0);
      checkOutput("midRstBusy", 0, 32'(busy[0]), 32'd0);
      checkOutput("midRstReady", 0, 32'(loadReady[0]), 32'd1);
      waitCycle();
      waitCycle();
      rst_n = 1'b1;
      repeat (6) waitCycle();
      checkOutput("midRstNoDone", 0, 32'(doneCnt[0] - doneBefore), 32'd0);
      fork
         applyStimulus(0, 4'h6);
         collectBits(0, 4, bits, enAll);
      join
      checkOutput("afterRstStream", 0, bits, 32'h6);
      repeat (3) waitCycle();

      // Loopback: the serial-in register holds the word on the FrameDone cycle.
      fork
         applyStimulus(0, 4'h9);
         collectBits(0, 4, bits, enAll);
      join
      checkOutput("loopbackDone", 0, 32'(frameDone[0]), 32'd1);
      checkOutput("loopbackWord", 0, 32'(sipo), 32'h9);
      repeat (3) waitCycle();

      // Random traffic on both instances with one reset pulse in the middle.
      for (int i = 0; i < 400; i++) begin
         for (int u = 0; u < NU; u++) begin
            loadValid[u] = ($urandom_range(0, 2) != 0);
            loadData[u]  = W'($urandom);
         end
         if (i == 200) rst_n = 1'b0;
         if (i == 203) rst_n = 1'b1;
         waitCycle();
      end
      for (int u = 0; u < NU; u++) loadValid[u] = 1'b0;
      repeat (30) waitCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/parallel_in_serial_out_ctrl.md
PARALLEL_IN_SERIAL_OUT_CTRL -- requirements
Module: parallel_in_serial_out_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: word width in bits; legal range 2..32.
REQ-002 Parameter GAP_CYCLES, default 1: idle cycles with ShiftEn low between frames; legal range 0..15.
REQ-003 clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 LoadData  input  WIDTH: parallel word to serialize.
REQ-006 LoadValid  input  1: LoadData is valid this cycle.
REQ-007 LoadReady  output  1: holding register is empty and can accept a word.
REQ-008 ShiftEn  output  1: ShiftOut carries a valid bit this cycle; drives the downstream shift-enable.
REQ-009 ShiftOut  output  1: serial data bit, MSB first; drives the downstream serial input.
REQ-010 FrameDone  output  1: one-cycle pulse marking completion of a word.
REQ-011 Busy  output  1: high whenever the state is not IDLE or the holding register is full.

Function
REQ-012 A word SHALL be accepted on a rising edge where LoadValid and LoadReady are both high; LoadData is captured into a one-entry holding register.
REQ-013 LoadReady SHALL equal NOT(holding register full), driven from a register with no combinational path from LoadValid.
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, GAP.
REQ-015 IDLE -> SHIFT on the edge where the holding register is full; that edge moves the word into the shift register, empties the holding register, and clears the bit counter.
REQ-016 In SHIFT, ShiftEn SHALL be 1 and ShiftOut SHALL be the current MSB of the shift register; the register shifts left by one bit on each edge.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, so bit WIDTH-1 of the word is emitted first and bit 0 last.
REQ-018 Latency: a word accepted at edge N SHALL present its MSB with ShiftEn high during the cycle after edge N+1.
REQ-019 On leaving SHIFT, FrameDone SHALL be high for exactly one cycle (the cycle after the last bit).
REQ-020 SHIFT -> GAP after the last bit when GAP_CYCLES > 0; GAP SHALL hold ShiftEn=0 and ShiftOut=0 for exactly GAP_CYCLES cycles.
REQ-021 At the end of GAP, or after the last bit when GAP_CYCLES = 0, the FSM SHALL go to SHIFT if the holding register is full, else to IDLE.
REQ-022 With GAP_CYCLES = 0 and a word waiting, ShiftEn SHALL stay high continuously across the frame boundary; FrameDone then coincides with the first bit of the next word.
REQ-023 The holding register SHALL accept a new word during SHIFT and GAP; the serial stream never loses or duplicates a word.
REQ-024 When LoadValid is high and LoadReady is low, the input SHALL be ignored and no state changes.
REQ-025 ShiftEn, ShiftOut and FrameDone SHALL be registered outputs, stable for the whole cycle.
REQ-026 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within a frame.

Reset
REQ-027 When rst_n is low, the block SHALL asynchronously enter IDLE with holding register empty, shift register 0 and counter 0.
REQ-028 Reset values: LoadReady=1, ShiftEn=0, ShiftOut=0, FrameDone=0, Busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no FrameDone; the partial word is discarded.
REQ-030 Reset deassertion SHALL take effect on the next clk edge with no extra synchronizer inside this block.

Structure
REQ-031 The state encoding (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) and the default WIDTH/GAP_CYCLES values SHALL live in the shared package piso_pkg.
REQ-032 The holding register plus its full flag SHALL be the sub-module piso_hold_reg; the FSM, counters and shifter stay in the top.

Verification (WIDTH=4, GAP_CYCLES=1 unless stated)
REQ-033 Load 4'b1011 from idle -> ShiftEn high 4 cycles, ShiftOut 1,0,1,1, then FrameDone=1 for 1 cycle, then 1 gap cycle, then IDLE with Busy=0.
REQ-034 Hold LoadValid with 4'hA then 4'h5 -> second word accepted one cycle after first load; stream is 1,0,1,0, gap, 0,1,0,1; exactly two FrameDone pulses.
REQ-035 GAP_CYCLES=0, words 4'hC and 4'h3 back-to-back -> ShiftEn high for 8 consecutive cycles, ShiftOut 1,1,0,0,0,0,1,1.
REQ-036 Assert rst_n low after 2 bits of 4'hF -> outputs immediately at reset values; no FrameDone; after release, loading 4'h6 yields 0,1,1,0.
REQ-037 Offer a third word while the holding register is full -> LoadReady=0; the word is not taken until LoadReady returns to 1, and the data still arrives intact.
REQ-038 Loopback into a 4-bit serial-in shift register clocked with its enable on ShiftEn -> the parallel output equals the loaded word (4'h9) on the FrameDone cycle.
